// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - DT_* access-type encodings carried on DataTypeM
//   - lsuState_t : FSM state codes of mem_stage_lsu
//   - accSize    : collapses a DataType code to byte/half/word (unknown -> word)
//   - extendLoad : picks the addressed lane of a read word and sign/zero extends it
package mem_stage_lsu_pkg;

  localparam logic [3:0] DT_W  = 4'd1;
  localparam logic [3:0] DT_H  = 4'd2;
  localparam logic [3:0] DT_HU = 4'd3;
  localparam logic [3:0] DT_B  = 4'd4;
  localparam logic [3:0] DT_BU = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsuState_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } accSize_t;

  function automatic accSize_t accSize(input logic [3:0] dt);
    case (dt)
      DT_H, DT_HU: return SZ_H;
      DT_B, DT_BU: return SZ_B;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic [31:0] extendLoad(input logic [3:0] dt,
                                             input logic [1:0] lo,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (dt)
      DT_B:    return {{24{b[7]}}, b};
      DT_BU:   return {24'b0, b};
      DT_H:    return {{16{h[15]}}, h};
      DT_HU:   return {16'b0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// lsu_lane_align: purely combinational lane steering for the LSU.
// Ports:
//   dataType   in  4   DT_* access type
//   addrLo     in  2   byte offset within the word
//   storeData  in  32  unshifted store data
//   loadWord   in  32  raw word returned by the bus
//   byteEn     out 4   byte enables for the access
//   laneData   out 32  store data replicated onto every lane it may land in
//   loadData   out 32  extracted and extended load result
//   misaligned out 1   word access off a word boundary or half off a half boundary
module lsu_lane_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [3:0]  dataType,
  input  logic [1:0]  addrLo,
  input  logic [31:0] storeData,
  input  logic [31:0] loadWord,
  output logic [3:0]  byteEn,
  output logic [31:0] laneData,
  output logic [31:0] loadData,
  output logic        misaligned
);

  always_comb begin
    byteEn     = 4'b1111;
    laneData   = storeData;
    misaligned = 1'b0;
    case (accSize(dataType))
      SZ_B: begin
        byteEn   = 4'b0001 << addrLo;
        laneData = {4{storeData[7:0]}};
      end
      SZ_H: begin
        byteEn     = addrLo[1] ? 4'b1100 : 4'b0011;
        laneData   = {2{storeData[15:0]}};
        misaligned = addrLo[0];
      end
      default: begin
        misaligned = |addrLo;
      end
    endcase
  end

  assign loadData = extendLoad(dataType, addrLo, loadWord);

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving a valid/grant/rvalid bus.
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-low reset
//   MemtoRegM/MemWriteM        load / store in M (both set -> store)
//   DataTypeM, ALUResM         access type and effective byte address
//   WriteDataM, PCM, HoldM     store data, PC of M instruction, external freeze
//   BusReq/BusWe/BusAddr       request valid, write strobe, word-aligned address
//   BusBE/BusWData             byte enables and lane-shifted store data
//   BusGnt/BusRValid/BusRData  request accepted, read data valid, read word
//   ReadDataM                  registered, extended load result
//   StallM                     freezes the front pipeline while an access is open
//   ExcAdEL/ExcAdES/ExcPC      misaligned load/store pulse and faulting PC
//   BusErr                     one-cycle pulse when the bus never answers
//   StateDbg                   current FSM state (lsuState_t encoding)
// Handshake: a request is accepted in the cycle BusReq && BusGnt are both high;
// read data is accepted in the WAIT cycle (or the accepting REQ cycle of a load)
// where BusRValid is high. Address, enables and data come straight from the
// frozen M-stage inputs, so they stay stable while StallM holds the pipeline.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [3:0]        DataTypeM,
  input  logic [31:0]       ALUResM,
  input  logic [31:0]       WriteDataM,
  input  logic [31:0]       PCM,
  input  logic              HoldM,
  output logic              BusReq,
  output logic              BusWe,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [3:0]        BusBE,
  output logic [31:0]       BusWData,
  input  logic              BusGnt,
  input  logic              BusRValid,
  input  logic [31:0]       BusRData,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              ExcAdEL,
  output logic              ExcAdES,
  output logic [31:0]       ExcPC,
  output logic              BusErr,
  output logic [1:0]        StateDbg
);

  lsuState_t   state;
  logic [7:0]  waitCnt;
  logic [31:0] loadData;
  logic        misaligned;
  logic        isStore, isLoad, startAcc, timeout, busy;

  lsu_lane_align uAlign (
    .dataType  (DataTypeM),
    .addrLo    (ALUResM[1:0]),
    .storeData (WriteDataM),
    .loadWord  (BusRData),
    .byteEn    (BusBE),
    .laneData  (BusWData),
    .loadData  (loadData),
    .misaligned(misaligned)
  );

  assign isStore  = MemWriteM;
  assign isLoad   = MemtoRegM & ~MemWriteM;
  assign busy     = (state == S_REQ) || (state == S_WAIT);
  assign startAcc = (state == S_IDLE) && (isStore || isLoad) && !misaligned;
  // The timeout cycle wins over a late grant/rvalid: the request is withdrawn.
  assign timeout  = busy && (waitCnt == 8'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      ReadDataM <= 32'b0;
      waitCnt   <= 8'b0;
    end else begin
      if (busy) waitCnt <= waitCnt + 8'd1;
      case (state)
        S_IDLE: begin
          if (startAcc) begin
            state   <= S_REQ;
            waitCnt <= 8'b0;
          end
        end
        S_REQ: begin
          if (timeout) begin
            state     <= S_DONE;
            ReadDataM <= 32'b0;
          end else if (BusGnt) begin
            if (isStore) begin
              state <= S_DONE;
            end else if (BusRValid) begin
              ReadDataM <= loadData;
              state     <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (timeout) begin
            state     <= S_DONE;
            ReadDataM <= 32'b0;
          end else if (BusRValid) begin
            ReadDataM <= loadData;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          // HoldM keeps the same instruction in M; stay here so it is not re-issued.
          if (!HoldM) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Control outputs are forced low while reset is asserted.
  assign BusReq   = reset && (state == S_REQ) && !timeout;
  assign StallM   = reset && (startAcc || busy);
  assign ExcAdEL  = reset && (state == S_IDLE) && isLoad && misaligned;
  assign ExcAdES  = reset && (state == S_IDLE) && isStore && misaligned;
  assign BusErr   = reset && timeout;
  assign ExcPC    = PCM;
  assign BusWe    = isStore;
  assign BusAddr  = {ALUResM[ADDR_W-1:2], 2'b00};
  assign StateDbg = state;

endmodule
